// File: rtl/imem_loader_if.sv
// Boot-link stream and instruction-memory write port of imem_loader.
// master: the environment (boot link source, memory, core reset sink).
// slave : the loader itself.
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic [15:0] im_addr;
   logic [15:0] im_data;
   logic        im_en;
   logic        im_wr;
   logic        cpu_rst_n;
   logic        done;
   logic        err;

   modport master (
      output in_valid, in_byte,
      input  in_ready, im_addr, im_data, im_en, im_wr, cpu_rst_n, done, err
   );

   modport slave (
      input  in_valid, in_byte,
      output in_ready, im_addr, im_data, im_en, im_wr, cpu_rst_n, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream (header word N, then N data words, each high byte
// first), writes the words to BASE_ADDR + 2*i and holds the core in reset
// until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
// word (16-bit sum of all data words); a mismatch aborts the load.
module imem_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] MAX_WORDS = 16'd4096
) (
   input logic          clk,
   input logic          rst_n,
   imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERROR
   } state_t;
`else
   typedef enum logic [3:0] {
      HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR
   } state_t;
`endif

   state_t      state;
   logic [7:0]  hi_byte;
   logic [15:0] word_cnt;
   logic [15:0] idx;
   logic [15:0] addr_q;
   logic [15:0] data_q;
   logic        wr_q;
   logic        cpu_rst_q;
   logic        done_q;
   logic        err_q;
   logic        ready;
   logic        accept;
   logic [15:0] rx_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [15:0] sum;
`endif

   assign accept  = bus.in_valid & ready;
   assign rx_word = {hi_byte, bus.in_byte};

   // Byte acceptance is decoded straight from the registered state.
   always_comb begin
      ready = 1'b0;
      case (state)
         HDR_HI, HDR_LO, DAT_HI, DAT_LO: ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM_HI, CSUM_LO:               ready = 1'b1;
`endif
         default:                        ready = 1'b0;
      endcase
   end

   // Load FSM with registered memory-port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HDR_HI;
         hi_byte   <= '0;
         word_cnt  <= '0;
         idx       <= '0;
         addr_q    <= BASE_ADDR;
         data_q    <= '0;
         wr_q      <= 1'b0;
         cpu_rst_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         wr_q <= 1'b0;
         case (state)
            HDR_HI: if (accept) begin
               hi_byte <= bus.in_byte;
               state   <= HDR_LO;
            end
            HDR_LO: if (accept) begin
               if (rx_word > MAX_WORDS) begin
                  state <= ERROR;
                  err_q <= 1'b1;
               end else if (rx_word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state     <= CSUM_HI;
`else
                  state     <= DONE;
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b1;
`endif
               end else begin
                  word_cnt <= rx_word;
                  state    <= DAT_HI;
               end
            end
            DAT_HI: if (accept) begin
               hi_byte <= bus.in_byte;
               state   <= DAT_LO;
            end
            DAT_LO: if (accept) begin
               data_q <= rx_word;
               addr_q <= BASE_ADDR + {idx[14:0], 1'b0};
               wr_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum    <= sum + rx_word;
`endif
               state  <= WRITE;
            end
            WRITE: begin
               idx <= idx + 16'd1;
               if (idx + 16'd1 == word_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state     <= CSUM_HI;
`else
                  state     <= DONE;
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b1;
`endif
               end else begin
                  state <= DAT_HI;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM_HI: if (accept) begin
               hi_byte <= bus.in_byte;
               state   <= CSUM_LO;
            end
            CSUM_LO: if (accept) begin
               if (rx_word == sum) begin
                  state     <= DONE;
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b1;
               end else begin
                  state <= ERROR;
                  err_q <= 1'b1;
               end
            end
`endif
            DONE:    state <= DONE;
            ERROR:   state <= ERROR;
            default: begin
               state <= ERROR;
               err_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready;
   assign bus.im_addr   = addr_q;
   assign bus.im_data   = data_q;
   assign bus.im_wr     = wr_q;
   assign bus.im_en     = wr_q;
   assign bus.cpu_rst_n = cpu_rst_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: two instances (BASE_ADDR 0x0000 and 0xFFFE)
// receive the same stream; writes and final status are compared against a
// stream-parsing reference model.
module tb_imem_loader;
   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] wr_q_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] wa[$];
   logic [31:0] wb[$];
   logic pa = 1'b0;
   logic pb = 1'b0;

   always #5 clk = ~clk;

   imem_loader_if a_if ();
   imem_loader_if b_if ();

   imem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'd4096))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   imem_loader #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(16'd4096))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         pa = 1'b0;
         pb = 1'b0;
      end else begin
         chk("im_en_a", 32'(a_if.im_en), 32'(a_if.im_wr));
         chk("im_en_b", 32'(b_if.im_en), 32'(b_if.im_wr));
         if (a_if.im_wr) begin
            chk("pulse_a", 32'(pa), 32'd0);
            wa.push_back({a_if.im_addr, a_if.im_data});
         end
         if (b_if.im_wr) begin
            chk("pulse_b", 32'(pb), 32'd0);
            wb.push_back({b_if.im_addr, b_if.im_data});
         end
         pa = a_if.im_wr;
         pb = b_if.im_wr;
      end
   end

   task automatic drive(input logic v, input logic [7:0] b);
      a_if.in_valid = v;
      b_if.in_valid = v;
      a_if.in_byte  = b;
      b_if.in_byte  = b;
   endtask

   // Reference: parse the stream by its rules; report writes, success and
   // how many bytes the loader should consume.
   function automatic void model(input byte_q_t s, input logic [15:0] base,
                                 output wr_q_t w, output logic ok, output int used);
      logic [15:0] n, sum, d;
      w   = {};
      sum = '0;
      n   = {s[0], s[1]};
      if (n > 16'd4096) begin
         ok   = 1'b0;
         used = 2;
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         d   = {s[2 + 2*i], s[3 + 2*i]};
         sum = sum + d;
         w.push_back({base + 16'(2*i), d});
      end
      used = 2 + 2*int'(n);
      ok   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ({s[used], s[used + 1]} != sum) ok = 1'b0;
      used = used + 2;
`endif
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00);
      repeat (2) @(negedge clk);
      wa.delete();
      wb.delete();
      rst_n = 1'b1;
   endtask

   // mode 0: valid always; 1: valid every other cycle; 2: random valid.
   task automatic send(input byte_q_t s, input int n, input int mode);
      int k = 0;
      int g = 0;
      logic v;
      while (k < n && g < 4000) begin
         @(negedge clk);
         case (mode)
            0:       v = 1'b1;
            1:       v = (g % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         drive(v, v ? s[k] : 8'($urandom));
         if (v && a_if.in_ready) k++;
         g++;
      end
      @(negedge clk);
      drive(1'b0, 8'h00);
      chk("send_complete", 32'(k), 32'(n));
   endtask

   task automatic check_reset_vals(input string t);
      chk({t, "_ready_a"}, 32'(a_if.in_ready), 32'd1);
      chk({t, "_addr_a"},  32'(a_if.im_addr),  32'h0000);
      chk({t, "_addr_b"},  32'(b_if.im_addr),  32'hFFFE);
      chk({t, "_data_a"},  32'(a_if.im_data),  32'd0);
      chk({t, "_wr_a"},    32'(a_if.im_wr),    32'd0);
      chk({t, "_en_a"},    32'(a_if.im_en),    32'd0);
      chk({t, "_cpurst_a"}, 32'(a_if.cpu_rst_n), 32'd0);
      chk({t, "_done_a"},  32'(a_if.done),     32'd0);
      chk({t, "_err_a"},   32'(a_if.err),      32'd0);
      chk({t, "_wr_b"},    32'(b_if.im_wr),    32'd0);
   endtask

   task automatic check_dut(input string t, input wr_q_t exp, input wr_q_t got,
                            input logic ok, input logic dn, input logic er,
                            input logic cr, input logic rd);
      chk({t, "_nwr"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk({t, "_write"}, got[i], exp[i]);
      chk({t, "_done"},   32'(dn), 32'(ok));
      chk({t, "_err"},    32'(er), 32'(!ok));
      chk({t, "_cpurst"}, 32'(cr), 32'(ok));
      chk({t, "_ready"},  32'(rd), 32'd0);
   endtask

   task automatic run_stream(input string t, input byte_q_t s, input int mode);
      wr_q_t ea, eb;
      logic oka, okb;
      int ua, ub, na, nb;
      do_reset();
      model(s, 16'h0000, ea, oka, ua);
      model(s, 16'hFFFE, eb, okb, ub);
      send(s, ua, mode);
      repeat (4) @(negedge clk);
      check_dut({t, "_a"}, ea, wa, oka, a_if.done, a_if.err, a_if.cpu_rst_n, a_if.in_ready);
      check_dut({t, "_b"}, eb, wb, okb, b_if.done, b_if.err, b_if.cpu_rst_n, b_if.in_ready);
      // Terminal states must ignore further bytes.
      na = wa.size();
      nb = wb.size();
      repeat (3) begin
         @(negedge clk);
         chk({t, "_term_ready"}, 32'(a_if.in_ready), 32'd0);
         drive(1'b1, 8'($urandom));
      end
      @(negedge clk);
      drive(1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk({t, "_term_nwr_a"}, 32'(wa.size()), 32'(na));
      chk({t, "_term_nwr_b"}, 32'(wb.size()), 32'(nb));
      chk({t, "_term_done"},  32'(a_if.done), 32'(oka));
   endtask

   initial begin
      byte_q_t s;
      logic [15:0] hdr, d, sum;
      int n;
      logic [31:0] x;

      drive(1'b0, 8'h00);
      do_reset();
      @(negedge clk);
      check_reset_vals("reset");

      // Basic two-word image.
`ifdef IMEM_LOADER_CHECKSUM_EN
      s = {8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h65, 8'h86};
`else
      s = {8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`endif
      run_stream("basic", s, 0);
      x = (wa.size() > 0) ? wa[0] : 'x;
      chk("basic_w0_a", x, {16'h0000, 16'hA1B2});
      x = (wa.size() > 1) ? wa[1] : 'x;
      chk("basic_w1_a", x, {16'h0002, 16'hC3D4});
      x = (wb.size() > 0) ? wb[0] : 'x;
      chk("wrap_w0_b", x, {16'hFFFE, 16'hA1B2});
      x = (wb.size() > 1) ? wb[1] : 'x;
      chk("wrap_w1_b", x, {16'h0000, 16'hC3D4});
      chk("basic_done_const", 32'(a_if.done), 32'd1);

      // Same image with in_valid toggling.
      run_stream("toggle", s, 1);

      // Header one past the limit.
      s = {8'h10, 8'h01, 8'h00, 8'h00};
      run_stream("hdr_over", s, 0);
      chk("hdr_over_err_const", 32'(a_if.err), 32'd1);

      // Empty image.
`ifdef IMEM_LOADER_CHECKSUM_EN
      s = {8'h00, 8'h00, 8'h00, 8'h00};
`else
      s = {8'h00, 8'h00};
`endif
      run_stream("empty", s, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum after one write.
      s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h12, 8'h35};
      run_stream("bad_csum", s, 0);
      chk("bad_csum_cpurst_const", 32'(a_if.cpu_rst_n), 32'd0);
`endif

      // Reset pulse during the first write strobe, then a fresh load.
`ifdef IMEM_LOADER_CHECKSUM_EN
      s = {8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h65, 8'h86};
`else
      s = {8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`endif
      do_reset();
      send(s, 4, 0);
      for (int t = 0; t < 10 && !a_if.im_wr; t++) @(negedge clk);
      chk("midrst_wr_seen", 32'(a_if.im_wr), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      run_stream("after_rst", s, 0);

      // Randomized images with random valid gaps.
      for (int it = 0; it < 10; it++) begin
         s   = {};
         n   = $urandom_range(1, 5);
         hdr = ($urandom_range(0, 5) == 0) ? 16'(16'h1001 + $urandom_range(0, 50)) : 16'(n);
         s.push_back(hdr[15:8]);
         s.push_back(hdr[7:0]);
         sum = '0;
         for (int i = 0; i < n; i++) begin
            d   = 16'($urandom);
            sum = sum + d;
            s.push_back(d[15:8]);
            s.push_back(d[7:0]);
         end
         if ($urandom_range(0, 3) == 0) sum = sum ^ 16'h0001;
         s.push_back(sum[15:8]);
         s.push_back(sum[7:0]);
         run_stream("rand", s, 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a program as a byte stream over a valid/ready handshake, assembles 16-bit words, and writes them into instruction memory through its write port while holding the processor core in reset. Once the last word is written, it releases the core, which then fetches from `BASE_ADDR`. It sits between the external boot link and the instruction-memory write port, beside the CPU top.

## Interface
- `BASE_ADDR`, 16'h0000, byte address of the first program word.
- `MAX_WORDS`, 16'd4096, largest legal word count in the header.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  a byte is offered on `in_byte`.
- `in_byte`  in  8  stream byte; each 16-bit value is sent high byte first.
- `in_ready`  out  1  loader accepts the byte this cycle.
- `im_addr`  out  16  instruction-memory byte address.
- `im_data`  out  16  word to write.
- `im_en`  out  1  memory enable; equal to `im_wr`.
- `im_wr`  out  1  single-cycle write strobe.
- `cpu_rst_n`  out  1  active-low reset to the core; low until the load completes.
- `done`  out  1  load completed successfully (sticky).
- `err`  out  1  load aborted (sticky).

## Operation
- Stream format: header word N (word count), then N data words. With the checksum feature compiled in, one checksum word follows the data.
- A byte transfers only on a cycle where both `in_valid` and `in_ready` are high.
- FSM states: `HDR_HI`, `HDR_LO`, `DAT_HI`, `DAT_LO`, `WRITE`, `CSUM_HI`, `CSUM_LO`, `DONE`, `ERROR`.
- Transitions:
  - `HDR_HI` to `HDR_LO` on a byte.
  - `HDR_LO` on a byte: if N > `MAX_WORDS`, go to `ERROR`. If N == 0, go to `CSUM_HI` (feature on) or `DONE` (feature off). Otherwise go to `DAT_HI`.
  - `DAT_HI` to `DAT_LO` on a byte.
  - `DAT_LO` to `WRITE` on a byte.
  - `WRITE` lasts one cycle, then goes to `DAT_HI` if words remain. Otherwise it goes to `CSUM_HI` (feature on) or `DONE`.
  - `CSUM_HI` to `CSUM_LO` on a byte. `CSUM_LO` on a byte goes to `DONE` on match, `ERROR` on mismatch.
- `in_ready` is 1 in the `HDR_*`, `DAT_*` and `CSUM_*` states and 0 in `WRITE`, `DONE` and `ERROR`.
- Word counter i starts at 0 and increments at the end of `WRITE`.
- Address for word i is `im_addr` = `BASE_ADDR` + 2·i, computed mod 2^16. Wrap past 16'hFFFE to 16'h0000 is permitted and silent.
- `DONE` and `ERROR` are terminal; only `rst_n` leaves them. Bytes offered while in these states are never accepted.
- `cpu_rst_n` is high only in `DONE`. It stays low in `ERROR` so that a bad image never runs.

## Timing
- Reset values: state `HDR_HI`, `in_ready` 1, `im_addr` = `BASE_ADDR`, `im_data` 0, `im_en` 0, `im_wr` 0, `cpu_rst_n` 0, `done` 0, `err` 0, counters and checksum 0.
- All outputs are registered. `in_ready` is decoded from the registered state.
- Write latency: the cycle after the low data byte is accepted, `im_wr` is 1 for exactly one cycle, with `im_addr` and `im_data` stable.
- Peak throughput is one word per 3 cycles.
- `in_valid` may drop between any two bytes. The FSM simply holds its state and partial word.
- `done` and `cpu_rst_n` rise together, one cycle after the final accepting or `WRITE` cycle. `err` rises one cycle after the offending byte.
- Reset mid-load: asynchronous assertion immediately forces all outputs to their reset values, including a write strobe in flight. The next load restarts from the header.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A 16-bit running sum (mod 2^16) of all data words is kept.
  - The stream carries a trailing checksum word.
  - A mismatch forces `ERROR`.
- Undefined:
  - The `CSUM_*` states and the sum register are absent.
  - The FSM goes from the last `WRITE` (or from N == 0) straight to `DONE`.

## Test plan
- Reset, then stream 00 02 A1 B2 C3 D4 (plus checksum 65 86 if the feature is on) -> two writes: 16'hA1B2 at 0x0000 and 16'hC3D4 at 0x0002. Then `done`=1, `cpu_rst_n`=1, `in_ready`=0.
- Same stream with `in_valid` toggling every other cycle -> identical writes. Each `im_wr` pulse lasts one cycle, and no byte is lost or duplicated.
- Header 0x1001 with `MAX_WORDS`=4096 -> `err`=1 and `cpu_rst_n` stays 0. No `im_wr` ever occurs.
- Header 00 00 -> zero writes. `done` follows the header (or follows checksum 00 00 when the feature is on).
- Feature on: image 00 01 12 34 with checksum 12 35 -> one write of 16'h1234, then `err`=1 and `cpu_rst_n`=0.
- `BASE_ADDR`=16'hFFFE, N=2 -> writes at 0xFFFE then 0x0000. Separately, pulse `rst_n` low after the first `im_wr` -> all outputs return to reset values, and a fresh full stream then loads correctly.
